// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one stage per shift-magnitude bit, LSB stage first,
// with a valid/ready handshake that stalls the whole pipe when the output is held.
module barrel_shifter_pipe #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Inp,
    input  logic [SHW-1:0]   Shift_Mag,
    input  logic [1:0]       Mode,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Outp
);

    logic [WIDTH-1:0] data_q  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic             valid_q [SHW];
    logic             valid_d [SHW];
    logic [1:0]       mode_q  [SHW];
    logic [1:0]       mode_d  [SHW];
    logic [SHW-1:0]   mag_q   [SHW];
    logic [SHW-1:0]   mag_d   [SHW];
    logic             adv_s;

    // Arithmetic mode fills from the current MSB, which stays equal to the
    // original sign bit because every earlier stage preserved it.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int unsigned      s
    );
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = d >> s;
            2'b01:   r = $signed(d) >>> s;
            2'b10:   r = (d >> s) | (d << (WIDTH - s));
            2'b11:   r = d << s;
            default: r = d;
        endcase
        return r;
    endfunction

    // Pipeline advance and the externally visible handshake/result.
    always_comb begin
        Out_Valid = valid_q[SHW-1];
        Outp      = data_q[SHW-1];
        adv_s     = Out_Ready || !valid_q[SHW-1];
        In_Ready  = adv_s;
    end

    // Next value of every stage; each stage consumes the low magnitude bit
    // and passes the remaining bits on, shifted down.
    always_comb begin
        data_d[0]  = Shift_Mag[0] ? shift_stage(Inp, Mode, 32'd1) : Inp;
        valid_d[0] = In_Valid;
        mode_d[0]  = Mode;
        mag_d[0]   = Shift_Mag >> 1;
        for (int k = 1; k < SHW; k++) begin
            data_d[k]  = mag_q[k-1][0] ? shift_stage(data_q[k-1], mode_q[k-1], 32'd1 << k)
                                       : data_q[k-1];
            valid_d[k] = valid_q[k-1];
            mode_d[k]  = mode_q[k-1];
            mag_d[k]   = mag_q[k-1] >> 1;
        end
    end

    // Stage registers: cleared by reset, loaded together only when the pipe advances.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= {WIDTH{1'b0}};
                valid_q[k] <= 1'b0;
                mode_q[k]  <= 2'b00;
                mag_q[k]   <= {SHW{1'b0}};
            end
        end else if (adv_s) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= data_d[k];
                valid_q[k] <= valid_d[k];
                mode_q[k]  <= mode_d[k];
                mag_q[k]   <= mag_d[k];
            end
        end
    end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have derived local parameter SHW = log2(WIDTH), default 4, giving the shift-magnitude width and the stage count.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 In_Valid  input  1  Inp/Shift_Mag/Mode are valid this cycle.
REQ-006 In_Ready  output  1  block accepts the input this cycle.
REQ-007 Inp  input  WIDTH  operand.
REQ-008 Shift_Mag  input  SHW  shift distance, 0..WIDTH-1.
REQ-009 Mode  input  2  operation: 00 logical right, 01 arithmetic right, 10 rotate right, 11 logical left.
REQ-010 Out_Valid  output  1  Outp holds a result.
REQ-011 Out_Ready  input  1  downstream accepts Outp this cycle.
REQ-012 Outp  output  WIDTH  shifted result.

Function
REQ-013 The block SHALL use SHW registered stages; stage k (k = 0..SHW-1) conditionally shifts by 2^k under control of Shift_Mag[k], LSB stage first.
REQ-014 Each stage register SHALL carry its data, a valid bit, Mode, and the not-yet-consumed Shift_Mag bits alongside the data.
REQ-015 The block SHALL transfer an input when In_Valid && In_Ready, and hand off a result when Out_Valid && Out_Ready.
REQ-016 Latency SHALL be exactly SHW cycles (4 at WIDTH=16) from the accepting edge to Out_Valid=1 when the output is not stalled; throughput is one operation per cycle.
REQ-017 The pipeline SHALL advance (signal adv) when Out_Ready || !Out_Valid, and In_Ready SHALL equal adv.
REQ-018 When adv=0, every stage register SHALL hold its value, and Outp/Out_Valid SHALL remain stable.
REQ-019 Bubbles SHALL propagate: a stage with valid=0 yields Out_Valid=0 when it reaches the output.
REQ-020 Mode 00 SHALL shift right, filling vacated bits with 0.
REQ-021 Mode 01 SHALL shift right, filling vacated bits with the original Inp[WIDTH-1].
REQ-022 Mode 10 SHALL rotate right, with bits leaving bit 0 re-entering at bit WIDTH-1.
REQ-023 Mode 11 SHALL shift left, filling vacated bits with 0.
REQ-024 Shift_Mag=0 SHALL return Inp unchanged in every mode.
REQ-025 Shift_Mag=WIDTH-1 SHALL leave one surviving bit in modes 00/11, all sign bits in mode 01, and a rotate-by-(WIDTH-1) in mode 10.
REQ-026 Simultaneous accept and output hand-off in the same cycle SHALL lose no data and create no duplicates.
REQ-027 Inputs presented while In_Ready=0 SHALL be ignored; the source must hold them.
REQ-028 No internal state machine beyond the valid pipeline SHALL exist; the block has no configuration registers.

Reset
REQ-029 Rst_n low SHALL immediately clear all stage valid bits, clear all data/Mode/magnitude registers, and drive Out_Valid=0 and Outp=0, independent of Clk.
REQ-030 In_Ready SHALL read 1 during and after reset, since Out_Valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result of them SHALL appear after release.
REQ-032 The first accept after reset SHALL be possible on the first rising edge with Rst_n high.

Verification (WIDTH=16)
REQ-033 Reset: Rst_n=0 with random inputs -> Out_Valid=0, Outp=16'h0000, In_Ready=1 throughout.
REQ-034 Mode directed: with Out_Ready=1, each case SHALL produce its result exactly 4 cycles after accept:
  - 16'hF00F, Mag=4, Mode 00 -> 16'h0F00.
  - 16'h8000, Mag=15, Mode 01 -> 16'hFFFF.
  - 16'h0001, Mag=1, Mode 10 -> 16'h8000.
  - 16'h0001, Mag=15, Mode 11 -> 16'h8000.
  - 16'hA5A5, Mag=0, any Mode -> 16'hA5A5.
REQ-035 Back-to-back: 16 consecutive accepts, Out_Ready=1 -> 16 consecutive Out_Valid cycles, in order, matching a reference model.
REQ-036 Stall: fill the pipe, drop Out_Ready for 5 cycles -> In_Ready=0 and Outp stable; on release, all results delivered in order with none lost or duplicated.
REQ-037 Reset mid-flight: 3 operations in the pipe, pulse Rst_n low between edges -> Out_Valid=0 immediately and stays 0 until a new operation completes 4 cycles after its accept.
REQ-038 Random: 10k random Inp/Mag/Mode with random In_Valid/Out_Ready -> scoreboard matches the model for all modes, including Mag=0 and Mag=15.
